// File: rtl/trdb_resync_scheduler.sv
// ---------------------------------------------------------------------------
// trdb_resync_scheduler
//
// Takes the resync counter's resync_max flag and turns it into a sync-packet
// request to the packet emitter. The request waits for a qualified
// instruction, or for the watchdog to expire, before it is raised. The block
// then waits for the emitter to confirm that the sync packet went out, and
// finally pulses a clear back to the resync counter.
//
// Parameters:
//   TIMEOUT_CYCLES    cycles a resync may stay outstanding before the
//                     request is forced and timeout_o asserts (2..65535)
//
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   trace_enabled_i   tracer enabled; low aborts any resync in progress
//   resync_max_i      resync counter at its maximum (level, sampled in IDLE)
//   qualified_i       a qualified instruction retires this cycle
//   sync_req_o        request to the emitter: next packet must be a sync
//   sync_ack_i        the emitter accepts the request (handshake with req)
//   sync_emitted_i    the emitter has output the sync packet (1-cycle pulse)
//   counter_clear_o   1-cycle pulse that clears the resync counter
//   resync_pending_o  resync outstanding; suppresses non-sync packets
//   timeout_o         watchdog expired for the current resync
// ---------------------------------------------------------------------------
module trdb_resync_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trace_enabled_i,
    input  logic resync_max_i,
    input  logic qualified_i,
    output logic sync_req_o,
    input  logic sync_ack_i,
    input  logic sync_emitted_i,
    output logic counter_clear_o,
    output logic resync_pending_o,
    output logic timeout_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PENDING   = 3'd1,
        REQ       = 3'd2,
        WAIT_EMIT = 3'd3,
        CLEAR     = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          holdoff;

    logic timer_max;
    assign timer_max = (timer == TIMER_MAX);

    // NOTE: every register in this block is updated with non-blocking
    // assignments so all of them see the same pre-edge values; blocking
    // assignments here would make the result depend on statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            timer   <= '0;
            holdoff <= 1'b0;
        end else if (!trace_enabled_i) begin
            // Disable beats any handshake or emit seen in the same cycle;
            // the resync is dropped without clearing the counter.
            state   <= IDLE;
            timer   <= '0;
            holdoff <= 1'b0;
        end else begin
            // The counter clears at the edge that leaves CLEAR, so its
            // resync_max flag may still read high for one more cycle.
            holdoff <= (state == CLEAR);

            // The watchdog runs only while a resync is outstanding and
            // saturates instead of wrapping so timeout_o stays asserted.
            case (state)
                PENDING, REQ, WAIT_EMIT: timer <= timer_max ? timer : timer + 1'b1;
                default:                 timer <= '0;
            endcase

            case (state)
                IDLE: begin
                    if (resync_max_i && !holdoff) state <= PENDING;
                end
                PENDING: begin
                    // A timed-out watchdog forces the request even without
                    // a qualified instruction to anchor the sync packet.
                    if (qualified_i || timer_max) state <= REQ;
                end
                REQ: begin
                    // Emitter may accept and emit in the same cycle; skip
                    // WAIT_EMIT so the emit pulse is not lost.
                    if (sync_ack_i) state <= sync_emitted_i ? CLEAR : WAIT_EMIT;
                end
                WAIT_EMIT: begin
                    if (sync_emitted_i) state <= CLEAR;
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state only.
    assign sync_req_o       = (state == REQ);
    assign counter_clear_o  = (state == CLEAR);
    assign resync_pending_o = (state == PENDING) || (state == REQ) || (state == WAIT_EMIT);
    assign timeout_o        = timer_max && resync_pending_o;

endmodule

// File: tb/tb_trdb_resync_scheduler.sv
// ---------------------------------------------------------------------------
// tb_trdb_resync_scheduler
//
// Directed bench for trdb_resync_scheduler with TIMEOUT_CYCLES = 8.
// Inputs are driven 1 ns after each rising edge. Outputs are checked at the
// same point, so they show the state that edge produced.
// ---------------------------------------------------------------------------
module tb_trdb_resync_scheduler;

    localparam int unsigned TO = 8;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic trace_enabled_i;
    logic resync_max_i;
    logic qualified_i;
    logic sync_req_o;
    logic sync_ack_i;
    logic sync_emitted_i;
    logic counter_clear_o;
    logic resync_pending_o;
    logic timeout_o;

    int checks = 0;
    int errors = 0;

    trdb_resync_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .trace_enabled_i  (trace_enabled_i),
        .resync_max_i     (resync_max_i),
        .qualified_i      (qualified_i),
        .sync_req_o       (sync_req_o),
        .sync_ack_i       (sync_ack_i),
        .sync_emitted_i   (sync_emitted_i),
        .counter_clear_o  (counter_clear_o),
        .resync_pending_o (resync_pending_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Check all four outputs: req, clear, pending, timeout.
    task automatic expect_out(input string tag, input logic req, input logic clr,
                              input logic pend, input logic to);
        check({tag, ".req"},   32'(sync_req_o),       32'(req));
        check({tag, ".clr"},   32'(counter_clear_o),  32'(clr));
        check({tag, ".pend"},  32'(resync_pending_o), 32'(pend));
        check({tag, ".to"},    32'(timeout_o),        32'(to));
    endtask

    // Apply one cycle of inputs, then advance to 1 ns past the next edge.
    task automatic cyc(input logic en, input logic rmax, input logic qual,
                       input logic ack, input logic emit);
        trace_enabled_i = en;
        resync_max_i    = rmax;
        qualified_i     = qual;
        sync_ack_i      = ack;
        sync_emitted_i  = emit;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni          = 1'b0;
        trace_enabled_i = 1'b1;
        resync_max_i    = 1'b0;
        qualified_i     = 1'b0;
        sync_ack_i      = 1'b0;
        sync_emitted_i  = 1'b0;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk_i);
        #1;
        expect_out("reset", 0, 0, 0, 0);
        check("reset.timer", 32'(dut.timer), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // An emit pulse in IDLE is ignored.
        cyc(1, 0, 0, 0, 1);
        expect_out("idle_emit", 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        expect_out("idle", 0, 0, 0, 0);

        // ---------------- nominal ----------------
        cyc(1, 1, 0, 0, 0);
        expect_out("nom.pend_entry", 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);                 // resync_max drops: no cancel
        expect_out("nom.pend_hold", 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0);                 // qualified
        expect_out("nom.req", 1, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);                 // no ack: req must stay
        expect_out("nom.req_hold", 1, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);                 // ack
        expect_out("nom.wait", 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        expect_out("nom.wait_hold", 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1);                 // emitted
        expect_out("nom.clear", 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        expect_out("nom.idle", 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        expect_out("nom.idle2", 0, 0, 0, 0);

        // ------- same-cycle ack+emit, then holdoff -------
        cyc(1, 1, 0, 0, 0);
        expect_out("ae.pend", 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0);
        expect_out("ae.req", 1, 0, 1, 0);
        cyc(1, 1, 0, 1, 1);                 // ack and emit together
        expect_out("ae.clear", 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);                 // resync_max still high in CLEAR
        expect_out("hold.idle1", 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);                 // 1 extra cycle: blocked
        expect_out("hold.idle2", 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);                 // 2nd extra cycle: new resync
        expect_out("hold.pend", 0, 0, 1, 0);
        check("hold.timer0", 32'(dut.timer), 0);

        // ---------------- forced request ----------------
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 1, 0, 0, 0);
            expect_out($sformatf("force.pend%0d", i), 0, 0, 1, 0);
        end
        cyc(1, 1, 0, 0, 0);
        expect_out("force.pend8_to", 0, 0, 1, 1);
        check("force.timer8", 32'(dut.timer), TO);
        cyc(1, 1, 0, 0, 0);                 // 9 cycles after entry
        expect_out("force.req", 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);             // emitter stalls
            expect_out($sformatf("force.stall%0d", i), 1, 0, 1, 1);
        end
        check("force.timer_sat", 32'(dut.timer), TO);

        // ---------------- abort ----------------
        cyc(1, 0, 0, 1, 0);
        expect_out("abort.wait", 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);                 // disable with emit same cycle
        expect_out("abort.idle", 0, 0, 0, 0);
        check("abort.timer", 32'(dut.timer), 0);
        cyc(1, 1, 0, 0, 0);                 // re-enable with resync_max
        expect_out("abort.restart", 0, 0, 1, 0);

        // Disable wins over a completing handshake.
        cyc(1, 0, 1, 0, 0);
        expect_out("dis.req", 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        expect_out("dis.idle", 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        expect_out("dis.no_clear", 0, 0, 0, 0);

        // ---------------- reset mid-REQ ----------------
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        expect_out("rst.req", 1, 0, 1, 0);
        #2;
        rst_ni = 1'b0;                      // between edges
        #1;
        check("rst.req_async",  32'(sync_req_o),       0);
        check("rst.pend_async", 32'(resync_pending_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1, 0, 0, 0, 0);
        expect_out("rst.idle", 0, 0, 0, 0);
        check("rst.timer", 32'(dut.timer), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/trdb_resync_scheduler.md
Name: trdb_resync_scheduler

Overview:
Consumer of the resync counter's resync_max flag inside the trace encoder. It turns a resync-max indication into a sync-packet request to the packet emitter using a valid/ack handshake. It then waits for the emitter to confirm the sync packet went out, and finally pulses a clear back to the resync counter. A watchdog forces the request if no qualified instruction arrives, and flags a stalled emitter.

Parameters:
TIMEOUT_CYCLES, 1024, cycles a resync may stay outstanding before timeout_o asserts and the request is forced; legal range 2..65535.
TW, $clog2(TIMEOUT_CYCLES+1), watchdog timer width; derived, not overridden.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_ni  input  1  asynchronous active-low reset
trace_enabled_i  input  1  tracer enabled; low aborts any resync in progress
resync_max_i  input  1  resync counter has reached its max value (level)
qualified_i  input  1  a qualified instruction retires this cycle (sync opportunity)
sync_req_o  output  1  request to emitter: next packet must be a sync packet
sync_ack_i  input  1  emitter accepts the request; handshake completes when sync_req_o && sync_ack_i
sync_emitted_i  input  1  emitter has output the sync packet (1-cycle pulse)
counter_clear_o  output  1  1-cycle pulse that clears the resync counter
resync_pending_o  output  1  resync outstanding; emitter uses it to suppress non-sync packet types
timeout_o  output  1  watchdog expired for the current resync

Behaviour:
- Async reset: state=IDLE, timer=0, holdoff=0; all outputs 0.
- All outputs are Moore outputs decoded from registered state:
  - sync_req_o = (state==REQ)
  - counter_clear_o = (state==CLEAR)
  - resync_pending_o = state in {PENDING, REQ, WAIT_EMIT}
  - timeout_o = (timer==TIMEOUT_CYCLES) && resync_pending_o
- IDLE: trace_enabled_i && resync_max_i && !holdoff -> PENDING.
- PENDING:
  - qualified_i -> REQ.
  - Otherwise, if timer reaches TIMEOUT_CYCLES -> REQ (forced request, no qualified instruction).
- REQ:
  - sync_req_o held high until handshake; must not drop without ack.
  - On ack: -> WAIT_EMIT, or -> CLEAR if sync_emitted_i is also high in the ack cycle.
- WAIT_EMIT: sync_emitted_i -> CLEAR. sync_emitted_i in any other state is ignored.
- CLEAR: one cycle, then -> IDLE. holdoff is set for exactly one cycle so a stale resync_max_i (the counter clears at this edge) cannot retrigger.
- Watchdog timer:
  - Zeroed in IDLE and CLEAR.
  - +1 per cycle in PENDING, REQ and WAIT_EMIT.
  - Saturates at TIMEOUT_CYCLES; no wrap.
  - timeout_o stays high until the state leaves pending; it is not an abort.
- trace_enabled_i low in any state: next state IDLE, timer=0, holdoff=0, no counter_clear_o pulse.
  - Disable has priority over qualified_i, sync_ack_i and sync_emitted_i in the same cycle.
  - A handshake completed in the disable cycle is discarded.
- resync_max_i deasserting while PENDING/REQ/WAIT_EMIT does not cancel; the resync completes.
- resync_max_i is sampled only in IDLE.
- Latency, all from the cycle the condition is sampled:
  - resync_max_i -> resync_pending_o = 1 cycle.
  - qualified_i -> sync_req_o = 1 cycle.
  - sync_emitted_i -> counter_clear_o = 1 cycle.
- Minimum back-to-back spacing: IDLE->PENDING->REQ->CLEAR (ack and emit together) ->IDLE, plus 1 holdoff cycle, gives 5 cycles between successive counter_clear_o pulses.

Test Plan:
- Nominal: enable=1, resync_max_i rises at cycle 10, qualified_i at 12, ack at 14, sync_emitted_i at 16 -> pending_o high cycles 11-16, sync_req_o high 13-14, counter_clear_o single pulse at 17, state IDLE at 18.
- Same-cycle ack+emit: in REQ, ack and sync_emitted_i together at cycle N -> counter_clear_o at N+1, no WAIT_EMIT cycle.
- Forced request: TIMEOUT_CYCLES=8, resync_max_i held, no qualified_i -> sync_req_o rises 9 cycles after PENDING entry and timeout_o is high; emitter stalls ack -> sync_req_o and timeout_o stay high, timer holds at 8.
- Abort: trace_enabled_i drops in WAIT_EMIT with sync_emitted_i high the same cycle -> next cycle IDLE, all outputs 0, no counter_clear_o pulse; re-enable with resync_max_i high -> new resync starts 1 cycle later.
- Holdoff: resync_max_i kept high through CLEAR and for 1 extra cycle -> no new PENDING entry; held high for 2 extra cycles -> PENDING entered exactly once.
- Reset mid-REQ: assert rst_ni=0 asynchronously between clock edges -> sync_req_o and resync_pending_o fall immediately; after release the block is in IDLE with timer 0.
